// File: rtl/pk_wrapper_pkg.sv
// pk_wrapper_pkg: shared types and cipher helpers for the pk_wrapper_mc slice.
//
// Contents:
//   eng_state_t   engine FSM states (IDLE, LOAD, ROUND, OUT)
//   boot_state_t  boot sequencer states
//   pk_req_t      host request record at the widest supported width
//   pk_rotl/pk_rotr, pk_round_fwd/pk_round_inv
//                 width-generic helpers: operands are carried in a PK_MAX_W
//                 container and every result is masked to the live width w.
//
// Optional feature macro: PK_WRAPPER_DECRYPT_EN adds the per-request mode bit.
package pk_wrapper_pkg;

    localparam int PK_MAX_W = 64;

    typedef logic [PK_MAX_W-1:0] pk_word_t;

    typedef enum logic [1:0] {
        ENG_IDLE,
        ENG_LOAD,
        ENG_ROUND,
        ENG_OUT
    } eng_state_t;

    typedef enum logic {
        BOOT_RUN,
        BOOT_DONE
    } boot_state_t;

    typedef struct packed {
`ifdef PK_WRAPPER_DECRYPT_EN
        logic     mode;
`endif
        pk_word_t account;
        pk_word_t password;
    } pk_req_t;

    function automatic pk_word_t pk_mask(input int w);
        return (w >= PK_MAX_W) ? '1 : ((pk_word_t'(1) << w) - pk_word_t'(1));
    endfunction

    // Rotate left by n within a w-bit word; n must be in 0..w-1.
    function automatic pk_word_t pk_rotl(input pk_word_t x, input int n, input int w);
        pk_word_t xm;
        xm = x & pk_mask(w);
        return ((xm << n) | (xm >> (w - n))) & pk_mask(w);
    endfunction

    function automatic pk_word_t pk_rotr(input pk_word_t x, input int n, input int w);
        return pk_rotl(x, (w - n) % w, w);
    endfunction

    // s' = rotl(s ^ k, 1) + k  (mod 2^w)
    function automatic pk_word_t pk_round_fwd(input pk_word_t s, input pk_word_t k, input int w);
        return (pk_rotl(s ^ k, 1 % w, w) + (k & pk_mask(w))) & pk_mask(w);
    endfunction

    // Inverse of pk_round_fwd: s = rotr(s' - k, 1) ^ k
    function automatic pk_word_t pk_round_inv(input pk_word_t s, input pk_word_t k, input int w);
        return (pk_rotr(s - k, 1 % w, w) ^ k) & pk_mask(w);
    endfunction

endpackage

// File: rtl/pk_wrapper_mc_fifo.sv
// pk_req_fifo: synchronous request FIFO with full/empty flags and occupancy.
//
// Ports:
//   clk, rst   clock, asynchronous active-low reset (pointers/count cleared)
//   push, din  write strobe and data; ignored while full
//   pop, dout  read strobe and head-of-queue data; ignored while empty
//   full, empty, count  status; push and pop on one edge leave count unchanged
module pk_req_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage is not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pk_wrapper_mc.sv
// pk_wrapper_mc: keyed multi-round password encryption wrapper.
//
// Requests {account, password} are queued in pk_req_fifo and encrypted one
// cipher round per cycle; results {account_out, password_enc} are held under
// backpressure. A boot sequence latches master_key before service starts.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Input side: valid=go, ready=in_ready. Output side: valid=done,
// ready=out_ready. done and its data stay stable until the transfer.
//
// Ports:
//   clk, rst            clock; async active-low reset (release expected
//                       synchronous to clk)
//   master_key          key, sampled on the last boot cycle
//   key_reload          pulse: restart boot (only when FIFO empty, engine IDLE)
//   go, in_ready        request valid / ready
//   account, password   request fields
//   mode                (PK_WRAPPER_DECRYPT_EN only) 1 = inverse cipher
//   done, out_ready     result valid / consumer ready
//   account_out, password_enc  result fields
//   boot_done_signal    key latched
//   busy                FIFO non-empty or engine not IDLE
//   eng_state, boot_state  FSM state observation
//
// Optional feature macro: PK_WRAPPER_DECRYPT_EN.
module pk_wrapper_mc
    import pk_wrapper_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ACCT_W      = 8,
    parameter int DEPTH       = 4,
    parameter int ROUNDS      = 4,
    parameter int BOOT_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] master_key,
    input  logic              key_reload,
    input  logic              go,
    output logic              in_ready,
    input  logic [ACCT_W-1:0] account,
    input  logic [DATA_W-1:0] password,
`ifdef PK_WRAPPER_DECRYPT_EN
    input  logic              mode,
`endif
    output logic              done,
    input  logic              out_ready,
    output logic [ACCT_W-1:0] account_out,
    output logic [DATA_W-1:0] password_enc,
    output logic              boot_done_signal,
    output logic              busy,
    output eng_state_t        eng_state,
    output boot_state_t       boot_state
);
`ifdef PK_WRAPPER_DECRYPT_EN
    localparam int REQ_W = 1 + ACCT_W + DATA_W;
`else
    localparam int REQ_W = ACCT_W + DATA_W;
`endif
    localparam int RW  = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam int BCW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;

    logic [REQ_W-1:0]           fifo_din;
    logic [REQ_W-1:0]           fifo_dout;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [$clog2(DEPTH+1)-1:0] fifo_count;
    logic                       push;
    logic                       pop;

    logic [DATA_W-1:0] key_q;
    logic [BCW-1:0]    boot_cnt;
    logic [ACCT_W-1:0] cur_acct;
    logic [DATA_W-1:0] cur_pwd;
    logic [DATA_W-1:0] s;
    logic [RW-1:0]     rnd;
    logic [DATA_W-1:0] round_key;
    logic [DATA_W-1:0] s_next;
    logic              last_round;
    int                key_idx;
`ifdef PK_WRAPPER_DECRYPT_EN
    logic              cur_mode;
    assign fifo_din = {mode, account, password};
`else
    assign fifo_din = {account, password};
`endif

    assign boot_done_signal = (boot_state == BOOT_DONE);
    assign in_ready         = boot_done_signal && !fifo_full;
    assign push             = go && in_ready;
    assign busy             = (fifo_count != '0) || (eng_state != ENG_IDLE);
    // Pop from IDLE, or straight out of OUT on the output transfer so that
    // back-to-back requests cost LOAD + ROUNDS + OUT cycles each.
    assign pop              = !fifo_empty &&
                              ((eng_state == ENG_IDLE) || (eng_state == ENG_OUT && out_ready));
    assign last_round       = (rnd == RW'(ROUNDS - 1));

    pk_req_fifo #(.DEPTH(DEPTH), .W(REQ_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // rnd counts rounds performed; decryption walks the key schedule backwards.
    always_comb begin
        key_idx = int'(rnd);
`ifdef PK_WRAPPER_DECRYPT_EN
        if (cur_mode) key_idx = ROUNDS - 1 - int'(rnd);
`endif
        round_key = DATA_W'(pk_rotl(PK_MAX_W'(key_q), key_idx % DATA_W, DATA_W)) ^ DATA_W'(cur_acct);
        s_next    = DATA_W'(pk_round_fwd(PK_MAX_W'(s), PK_MAX_W'(round_key), DATA_W));
`ifdef PK_WRAPPER_DECRYPT_EN
        if (cur_mode) s_next = DATA_W'(pk_round_inv(PK_MAX_W'(s), PK_MAX_W'(round_key), DATA_W));
`endif
    end

    // Boot sequencer: BOOT_CYCLES cycles, key latched on the last one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            boot_state <= BOOT_RUN;
            boot_cnt   <= '0;
            key_q      <= '0;
        end else begin
            case (boot_state)
                BOOT_RUN: begin
                    if (boot_cnt == BCW'(BOOT_CYCLES - 1)) begin
                        key_q      <= master_key;
                        boot_state <= BOOT_DONE;
                    end else begin
                        boot_cnt <= boot_cnt + BCW'(1);
                    end
                end
                BOOT_DONE: begin
                    if (key_reload && fifo_empty && eng_state == ENG_IDLE) begin
                        boot_cnt   <= '0;
                        boot_state <= BOOT_RUN;
                    end
                end
                default: boot_state <= BOOT_RUN;
            endcase
        end
    end

    // Cipher engine.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            eng_state    <= ENG_IDLE;
            cur_acct     <= '0;
            cur_pwd      <= '0;
            s            <= '0;
            rnd          <= '0;
            done         <= 1'b0;
            account_out  <= '0;
            password_enc <= '0;
`ifdef PK_WRAPPER_DECRYPT_EN
            cur_mode     <= 1'b0;
`endif
        end else begin
            case (eng_state)
                ENG_IDLE: begin
                    if (pop) begin
                        cur_acct  <= fifo_dout[DATA_W +: ACCT_W];
                        cur_pwd   <= fifo_dout[0 +: DATA_W];
`ifdef PK_WRAPPER_DECRYPT_EN
                        cur_mode  <= fifo_dout[REQ_W-1];
`endif
                        eng_state <= ENG_LOAD;
                    end
                end
                ENG_LOAD: begin
                    s         <= cur_pwd;
                    rnd       <= '0;
                    eng_state <= ENG_ROUND;
                end
                ENG_ROUND: begin
                    s <= s_next;
                    if (last_round) begin
                        done         <= 1'b1;
                        account_out  <= cur_acct;
                        password_enc <= s_next;
                        eng_state    <= ENG_OUT;
                    end else begin
                        rnd <= rnd + RW'(1);
                    end
                end
                ENG_OUT: begin
                    if (out_ready) begin
                        done <= 1'b0;
                        if (pop) begin
                            cur_acct  <= fifo_dout[DATA_W +: ACCT_W];
                            cur_pwd   <= fifo_dout[0 +: DATA_W];
`ifdef PK_WRAPPER_DECRYPT_EN
                            cur_mode  <= fifo_dout[REQ_W-1];
`endif
                            eng_state <= ENG_LOAD;
                        end else begin
                            eng_state <= ENG_IDLE;
                        end
                    end
                end
                default: eng_state <= ENG_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pk_wrapper_mc.sv
// tb_pk_wrapper_mc: scoreboard bench for pk_wrapper_mc (DATA_W=8, ACCT_W=4,
// ROUNDS=2, DEPTH=4, BOOT_CYCLES=8). Expected results come from a reference
// cipher written directly from the key-schedule and round equations.
module tb_pk_wrapper_mc;
  import pk_wrapper_pkg::*;

  localparam int DATA_W      = 8;
  localparam int ACCT_W      = 4;
  localparam int DEPTH       = 4;
  localparam int ROUNDS      = 2;
  localparam int BOOT_CYCLES = 8;

  // ---------------- clock / reset / signals ----------------
  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [DATA_W-1:0] master_key;
  logic              key_reload;
  logic              go;
  logic              in_ready;
  logic [ACCT_W-1:0] account;
  logic [DATA_W-1:0] password;
  logic              mode_in;
  logic              done;
  logic              out_ready;
  logic [ACCT_W-1:0] account_out;
  logic [DATA_W-1:0] password_enc;
  logic              boot_done_signal;
  logic              busy;
  eng_state_t        dbg_eng;
  boot_state_t       dbg_boot;

  initial forever #5 clk = ~clk;

  pk_wrapper_mc #(
    .DATA_W(DATA_W), .ACCT_W(ACCT_W), .DEPTH(DEPTH),
    .ROUNDS(ROUNDS), .BOOT_CYCLES(BOOT_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .master_key(master_key),
    .key_reload(key_reload),
    .go(go),
    .in_ready(in_ready),
    .account(account),
    .password(password),
`ifdef PK_WRAPPER_DECRYPT_EN
    .mode(mode_in),
`endif
    .done(done),
    .out_ready(out_ready),
    .account_out(account_out),
    .password_enc(password_enc),
    .boot_done_signal(boot_done_signal),
    .busy(busy),
    .eng_state(dbg_eng),
    .boot_state(dbg_boot)
  );

  // ---------------- scoreboard state ----------------
  logic [ACCT_W+DATA_W-1:0] exp_q[$];
  int checks = 0;
  int fails  = 0;
  logic [DATA_W-1:0] key_model;
  logic rand_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] ref_enc(input logic [7:0] key, input logic [3:0] acct,
                                         input logic [7:0] pwd, input logic md);
    logic [7:0] st;
    logic [7:0] k;
    st = pwd;
    if (!md) begin
      for (int r = 0; r < ROUNDS; r++) begin
        k  = rotl8(key, r % 8) ^ {4'b0000, acct};
        st = rotl8(st ^ k, 1) + k;
      end
    end else begin
      for (int r = ROUNDS - 1; r >= 0; r--) begin
        k  = rotl8(key, r % 8) ^ {4'b0000, acct};
        st = rotl8(st - k, 7) ^ k;
      end
    end
    return st;
  endfunction

  // ---------------- driver tasks (called at posedge+#1) ----------------
  task automatic send(input logic [3:0] a, input logic [7:0] p, input logic [7:0] e);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("send_in_ready", in_ready, 1);
    if (in_ready) begin
      go = 1'b1; account = a; password = p;
      @(posedge clk);
      exp_q.push_back({a, e});
      #1 go = 1'b0;
    end
  endtask

  task automatic send_rand();
    logic [3:0] a;
    logic [7:0] p;
    a = 4'($urandom_range(0, 15));
    p = 8'($urandom_range(0, 255));
`ifdef PK_WRAPPER_DECRYPT_EN
    mode_in = 1'($urandom_range(0, 1));
`endif
    send(a, p, ref_enc(key_model, a, p, mode_in));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic wait_boot(input string name);
    int n;
    n = 0;
    while (!boot_done_signal && n < 50) begin
      chk({name, "_in_ready_low"}, in_ready, 0);
      @(posedge clk); #1; n++;
    end
    chk({name, "_cycles"}, n, BOOT_CYCLES);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_in_ready"}, in_ready, 0);
    chk({name, "_done"}, done, 0);
    chk({name, "_account_out"}, account_out, 0);
    chk({name, "_password_enc"}, password_enc, 0);
    chk({name, "_boot_done"}, boot_done_signal, 0);
    chk({name, "_busy"}, busy, 0);
  endtask

  task automatic random_phase(input int count);
    rand_ready = 1'b1;
    for (int i = 0; i < count; i++) begin
      send_rand();
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    wait_drain();
  endtask

  // random out_ready while enabled
  initial forever begin
    @(posedge clk); #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    logic held;
    logic [ACCT_W+DATA_W-1:0] held_val;
    logic [ACCT_W+DATA_W-1:0] e;
    held = 1'b0;
    held_val = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        held = 1'b0;
      end else if (done) begin
        if (held) chk("hold_stable", {account_out, password_enc}, held_val);
        if (out_ready) begin
          held = 1'b0;
          if (exp_q.size() == 0) begin
            chk("unexpected_done", done, 0);
          end else begin
            e = exp_q.pop_front();
            chk("result", {account_out, password_enc}, e);
          end
        end else begin
          held = 1'b1;
          held_val = {account_out, password_enc};
        end
      end else begin
        if (held) chk("done_held", done, 1);
        held = 1'b0;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures", checks, fails);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int n;
    go = 1'b0; account = '0; password = '0; out_ready = 1'b1;
    key_reload = 1'b0; master_key = 8'h00; mode_in = 1'b0; key_model = 8'h00;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1;

    // Boot with go held high: no request may be accepted before boot_done.
    go = 1'b1;
    account = 4'($urandom_range(0, 15));
    password = 8'($urandom_range(0, 255));
    rst = 1'b1;
    wait_boot("boot");
    go = 1'b0;
    chk("post_boot_in_ready", in_ready, 1);
    repeat (6) begin @(posedge clk); #1; end
    chk("boot_go_ignored_busy", busy, 0);

    // Single request with zero key; done exactly ROUNDS+2 cycles after accept.
    send(4'h0, 8'h01, 8'h04);
    n = 0;
    while (!done && n < 20) begin @(posedge clk); #1; n++; end
    chk("latency", n, ROUNDS + 2);
    wait_drain();

    random_phase(20);

    // Backpressure: 5 back-to-back with out_ready low.
    repeat (3) begin @(posedge clk); #1; end
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_rand();
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_busy", busy, 1);
    repeat (6) begin @(posedge clk); #1; end
    chk("bp_done_held", done, 1);
    chk("bp_in_ready_still_low", in_ready, 0);
    out_ready = 1'b1;
    wait_drain();

    // Reset while the engine is in ROUND.
    repeat (3) begin @(posedge clk); #1; end
    send_rand();
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_state_round", dbg_eng, ENG_ROUND);
    rst = 1'b0;
    exp_q.delete();
    #1;
    check_reset_outputs("mid_reset");
    @(posedge clk); #1;
    rst = 1'b1;
    wait_boot("reboot");
    repeat (8) begin @(posedge clk); #1; end
    chk("after_reset_no_done", done, 0);
    chk("after_reset_busy", busy, 0);

    // key_reload while idle: new key 0x81.
    master_key = 8'h81;
    key_reload = 1'b1;
    @(posedge clk); #1;
    key_reload = 1'b0;
    chk("reload_boot_cleared", boot_done_signal, 0);
    wait_boot("reload");
    key_model = 8'h81;
    send(4'h1, 8'h00, 8'h09);
    wait_drain();

    // key_reload while busy is ignored; key stays 0x81.
    master_key = 8'h00;
    send_rand();
    chk("busy_before_reload", busy, 1);
    key_reload = 1'b1;
    @(posedge clk); #1;
    key_reload = 1'b0;
    chk("reload_busy_ignored", boot_done_signal, 1);
    chk("reload_busy_in_ready", in_ready, 1);
    wait_drain();
    send(4'h2, 8'h5a, ref_enc(8'h81, 4'h2, 8'h5a, 1'b0));
    wait_drain();

    random_phase(12);

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
